instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
PC generator and fetch buffer directly upstream of instr_rom. Drives the ROM's registered word address and captures the 32-bit instruction the ROM returns one cycle later. Presents instructions with their byte PC to decode through a valid/ready handshake. Accepts branch/jump redirects, which flush all in-flight and buffered fetches.

Parameters:
ADDR_W, 10, ROM word-address width; must match instr_rom address_parameter.
RESET_PC, 32'h0000_0000, byte PC loaded on reset.
FIFO_DEPTH, 3, fetch buffer entries; minimum 2; 3 gives one instruction per cycle.

Ports:
clk  input  1  rising-edge clock shared with instr_rom
rst_n  input  1  asynchronous active-low reset
rom_addr  output  ADDR_W  word address to instr_rom = pc_q[ADDR_W+1:2]
rom_instr  input  32  instr_rom output, valid the cycle after rom_addr was sampled
redirect_valid  input  1  single-cycle redirect request
redirect_pc  input  32  redirect target byte address
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts
if_instr  output  32  instruction word
if_pc  output  32  byte PC of if_instr

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC; resp_v_q=0; FIFO count=0.
  - if_valid=0, if_instr=0, if_pc=0.
  - rom_addr=RESET_PC[ADDR_W+1:2].
- rom_addr comes only from pc_q. No combinational path from if_ready or redirect_valid to rom_addr.
- Issue rule: issue_en = (count_q + resp_v_q) < FIFO_DEPTH. This depends on registered state only.
- On issue at a rising edge: resp_v_q<=1; resp_pc_q<=pc_q; pc_q<=pc_q+4 (32-bit, wraps modulo 2^32).
- Without issue: resp_v_q<=0 and pc_q holds.
- Response: when resp_v_q=1, {rom_instr, resp_pc_q} is pushed into the FIFO at the next edge. A response is never dropped, except by a redirect.
- Output: if_valid = count_q!=0. if_instr and if_pc are the FIFO head, driven from registers.
- Pop on if_valid && if_ready. Push and pop in the same cycle are allowed; count is unchanged.
- While if_valid=1 and if_ready=0, if_instr and if_pc hold stable.
- Latency:
  - First if_valid rises 2 cycles after the first edge with rst_n=1: issue edge, then push edge.
  - Steady state with if_ready=1 and FIFO_DEPTH=3: one instruction per cycle.
- Redirect (redirect_valid=1 at an edge) has the highest priority:
  - pc_q<=redirect_pc with bits [1:0] forced to 0.
  - FIFO count<=0 and resp_v_q<=0. Any same-cycle issue, push or pop is discarded.
  - A handshake in the same cycle as the redirect is considered complete by decode; the FIFO is flushed regardless.
  - First if_valid for the target rises 2 edges after the redirect edge. Back-to-back redirects: the last one wins.
- ROM wrap: rom_addr uses only pc bits [ADDR_W+1:2], so fetch wraps every 4*2^ADDR_W bytes. if_pc reports the full 32-bit PC.
- Buffer full (count=FIFO_DEPTH): issue stops, rom_addr holds, and no response is lost.
- Reset mid-operation: immediate return to the reset values above. The buffer and in-flight fetch are discarded.

Optional Feature:
IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output if_misaligned (1 bit), reset 0.
  - A redirect with redirect_pc[1:0]!=0 flushes as normal, issues nothing, and on the next edge pushes one entry {instr=32'h0000_0013, pc=redirect_pc unmodified, misaligned=1}.
  - Issue stays disabled until the next redirect.
  - if_misaligned accompanies the head entry; it is 0 for normal fetches.
- Undefined: no port; redirect_pc[1:0] is ignored.

Test Plan:
- Reset then stream: ROM words hold their own index, RESET_PC=0, if_ready=1 → if_valid rises 2 cycles after reset release; if_pc 0,4,8,… and if_instr 0,1,2,… one per cycle, no gaps.
- Backpressure: if_ready=0 for 5 cycles mid-stream → if_valid=1 held, if_pc/if_instr stable, rom_addr frozen once count=3; after release the sequence continues with no skip or duplicate.
- Redirect: redirect_pc=0x100 pulse while the FIFO holds 2 entries → next cycle if_valid=0; 2 edges later if_pc=0x100, if_instr=64; stale entries never appear.
- Redirect with ready toggling: redirect in the same cycle as a pop and as a push → FIFO empty next cycle; only target instructions follow.
- Wrap: redirect to 0xFFC with ADDR_W=10 → rom_addr 1023 then 0; if_pc 0xFFC then 0x1000.
- With IF_MISALIGN_CHK_EN, redirect_pc=0x102 → one entry with if_misaligned=1, if_pc=0x102, if_instr=0x13, then no further if_valid until a redirect to 0x200 resumes normal fetch.

Source files
------------

// File: rtl/instr_fetch.sv
// PC generator and fetch buffer in front of instr_rom: issues word addresses, buffers returned words.
// Optional IF_MISALIGN_CHK_EN: misaligned redirects inject one flagged NOP and halt issue until the next redirect.
module instr_fetch #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
`ifdef IF_MISALIGN_CHK_EN
  ,output logic             if_misaligned
`endif
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic             resp_v_q, resp_v_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_instr_q [FIFO_DEPTH];
  logic [31:0]      mem_pc_q    [FIFO_DEPTH];

  logic [CNT_W:0]   occ;
  logic             issue_en;
  logic             push;
  logic             pop;
  logic             mem_we;
  logic [31:0]      push_instr;

`ifdef IF_MISALIGN_CHK_EN
  logic             resp_mis_q, resp_mis_d;
  logic             lock_q, lock_d;
  logic             mem_mis_q [FIFO_DEPTH];
  logic             redirect_mis;
`else
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign if_valid = (count_q != '0);
  assign if_instr = mem_instr_q[rd_ptr_q];
  assign if_pc    = mem_pc_q[rd_ptr_q];
`ifdef IF_MISALIGN_CHK_EN
  assign if_misaligned = mem_mis_q[rd_ptr_q];
  assign redirect_mis  = (redirect_pc[1:0] != 2'b00);
  assign push_instr    = resp_mis_q ? NOP_INSTR : rom_instr;
`else
  assign push_instr    = rom_instr;
`endif

  // Occupancy counts the in-flight fetch so a returning word always has a free slot.
  always_comb begin
    occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, resp_v_q};
    issue_en = (occ < DEPTH_C);
`ifdef IF_MISALIGN_CHK_EN
    if (lock_q) issue_en = 1'b0;
`endif
    push      = resp_v_q;
    pop       = if_valid && if_ready;
    mem_we    = push && !redirect_valid;
    pc_d      = pc_q;
    resp_v_d  = 1'b0;
    resp_pc_d = resp_pc_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
`ifdef IF_MISALIGN_CHK_EN
    resp_mis_d = 1'b0;
    lock_d     = lock_q;
`endif
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
`ifdef IF_MISALIGN_CHK_EN
      lock_d     = redirect_mis;
      resp_v_d   = redirect_mis;
      resp_mis_d = redirect_mis;
      resp_pc_d  = redirect_pc;
`endif
    end else begin
      resp_v_d = issue_en;
      if (issue_en) begin
        pc_d      = pc_q + 32'd4;
        resp_pc_d = pc_q;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_v_q  <= 1'b0;
      resp_pc_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef IF_MISALIGN_CHK_EN
      resp_mis_q <= 1'b0;
      lock_q     <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      resp_v_q  <= resp_v_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
`ifdef IF_MISALIGN_CHK_EN
      resp_mis_q <= resp_mis_d;
      lock_q     <= lock_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
`ifdef IF_MISALIGN_CHK_EN
        mem_mis_q[i]   <= 1'b0;
`endif
      end
    end else if (mem_we) begin
      mem_instr_q[wr_ptr_q] <= push_instr;
      mem_pc_q[wr_ptr_q]    <= resp_pc_q;
`ifdef IF_MISALIGN_CHK_EN
      mem_mis_q[wr_ptr_q]   <= resp_mis_q;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM words hold their own index; a stream model checks every cycle.
module tb_instr_fetch;
  localparam int          ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              if_valid;
  logic              if_ready = 1'b1;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
`ifdef IF_MISALIGN_CHK_EN
  logic              if_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .FIFO_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef IF_MISALIGN_CHK_EN
    ,.if_misaligned(if_misaligned)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_instr <= {22'b0, rom_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stream model: after a start (reset or redirect) decode sees consecutive PCs,
  // the first two edges after the start produce nothing, then one word is always available.
  logic [31:0] exp_pc   = RESET_PC;
  int          since    = 0;
  bit          mis_mode = 0;
  bit          mis_done = 0;
  logic [31:0] mis_pc   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mis_mode) begin
        chk("mis_valid", {31'b0, if_valid}, {31'b0, (since >= 1 && !mis_done)});
        if (if_valid) begin
          chk("mis_pc", if_pc, mis_pc);
          chk("mis_instr", if_instr, 32'h0000_0013);
`ifdef IF_MISALIGN_CHK_EN
          chk("mis_flag", {31'b0, if_misaligned}, 32'd1);
`endif
        end
      end else begin
        chk("model_valid", {31'b0, if_valid}, {31'b0, (since >= 2)});
        if (if_valid) begin
          chk("model_pc", if_pc, exp_pc);
          chk("model_instr", if_instr, {22'b0, exp_pc[11:2]});
`ifdef IF_MISALIGN_CHK_EN
          chk("model_misflag", {31'b0, if_misaligned}, 32'd0);
`endif
        end
      end
    end
    if (!rst_n) begin
      exp_pc   = RESET_PC;
      since    = 0;
      mis_mode = 0;
    end else if (redirect_valid) begin
      since    = 0;
      mis_mode = 0;
      exp_pc   = {redirect_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        mis_mode = 1;
        mis_done = 0;
        mis_pc   = redirect_pc;
      end
`endif
    end else begin
      if (if_valid && if_ready) begin
        if (mis_mode) mis_done = 1;
        else          exp_pc   = exp_pc + 32'd4;
      end
      if (since < 100) since++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  logic [7:0] ready_pat;

  initial begin
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_rom_addr", {22'b0, rom_addr}, 32'd0);

    tick(1);
    rst_n = 1'b1;
    @(negedge clk); chk("lat_0", {31'b0, if_valid}, 32'd0);
    @(negedge clk); chk("lat_1", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'd0);
    chk("first_instr", if_instr, 32'd0);
    @(negedge clk);
    chk("second_pc", if_pc, 32'd4);
    chk("second_instr", if_instr, 32'd1);
    chk("steady_rom_addr", {22'b0, rom_addr}, 32'd3);

    // backpressure for 5 edges with head at pc 20
    tick(4);
    if_ready = 1'b0;
    tick(2);
    @(negedge clk); chk("stall_rom_addr_a", {22'b0, rom_addr}, 32'd8);
    tick(2);
    @(negedge clk);
    chk("stall_rom_addr_b", {22'b0, rom_addr}, 32'd8);
    chk("stall_pc", if_pc, 32'd20);
    chk("stall_instr", if_instr, 32'd5);
    chk("stall_valid", {31'b0, if_valid}, 32'd1);
    tick(1);
    if_ready = 1'b1;

    // redirect with two buffered entries
    tick(6);
    if_ready = 1'b0;
    tick(1);
    redirect(32'h100);
    if_ready = 1'b1;
    @(negedge clk); chk("redir_flush", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("redir_pc", if_pc, 32'h100);
    chk("redir_instr", if_instr, 32'd64);

    // redirect during a simultaneous push and pop
    tick(3);
    redirect(32'h40);
    @(negedge clk); chk("redir_pp_flush", {31'b0, if_valid}, 32'd0);

    tick(4);
    ready_pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      if_ready = ready_pat[i];
      if (i == 5) redirect(32'h80);
      else        tick(1);
    end
    if_ready = 1'b1;
    tick(4);

    // ROM address wrap
    redirect(32'hFFC);
    @(negedge clk); chk("wrap_rom_1023", {22'b0, rom_addr}, 32'd1023);
    @(negedge clk); chk("wrap_rom_0", {22'b0, rom_addr}, 32'd0);
    @(negedge clk);
    chk("wrap_pc_a", if_pc, 32'hFFC);
    chk("wrap_instr_a", if_instr, 32'd1023);
    @(negedge clk);
    chk("wrap_pc_b", if_pc, 32'h1000);
    chk("wrap_instr_b", if_instr, 32'd0);

    // back-to-back redirects, last wins
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick(1);
    redirect(32'h300);
    @(negedge clk); chk("b2b_flush", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_pc", if_pc, 32'h300);
    chk("b2b_instr", if_instr, 32'hC0);

    // asynchronous reset mid-stream
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_rom_addr", {22'b0, rom_addr}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);

`ifdef IF_MISALIGN_CHK_EN
    redirect(32'h102);
    @(negedge clk); chk("mis_flush", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    chk("mis_valid_lit", {31'b0, if_valid}, 32'd1);
    chk("mis_pc_lit", if_pc, 32'h102);
    chk("mis_instr_lit", if_instr, 32'h13);
    chk("mis_flag_lit", {31'b0, if_misaligned}, 32'd1);
    tick(4);
    @(negedge clk); chk("mis_halt", {31'b0, if_valid}, 32'd0);
    redirect(32'h200);
    tick(5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
